// File: rtl/ccd_line_merge.sv
// ccd_line_merge
// Merges the two-channel CCD readout (left half ascending on AFE_DL, right half
// descending on AFE_DR) into one left-to-right line on CPU_VD, framed by
// CPU_HSYNC / CPU_VSYNC. Lines are captured into one bank of a ping-pong buffer
// while the other bank is read out.
//
// Build option: define USHI_TEST_PATTERN_EN to store the column index instead
// of AFE data, so every emitted line is the ramp 0..2*LINE_PIX-1.
//
// Readout FSM:
//   state | meaning
//   IDLE  | no line being emitted, ready to accept a completed line
//   READ  | issuing buffer addresses 0..2*LINE_PIX-1, one per cycle
module ccd_line_merge #(
  parameter int LINE_PIX    = 1024,
  parameter int FRAME_LINES = 1000
) (
  input  logic        CLK_60M,
  input  logic        CPU_RST,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [13:0] AFE_DL,
  input  logic [13:0] AFE_DR,
  output logic [13:0] CPU_VD,
  output logic        CPU_HSYNC,
  output logic        CPU_VSYNC,
  output logic        overrun
);

  localparam int KW  = $clog2(LINE_PIX + 1);
  localparam int KIW = $clog2(LINE_PIX);
  localparam int AW  = $clog2(2 * LINE_PIX);
  localparam int LW  = $clog2(FRAME_LINES + 2);

  localparam logic [KW-1:0]  K_FULL  = KW'(LINE_PIX);
  localparam logic [KIW-1:0] I_LAST  = KIW'(LINE_PIX - 1);
  localparam logic [AW-1:0]  A_LAST  = AW'(2 * LINE_PIX - 1);
  localparam logic [AW-1:0]  A_HALF  = AW'(LINE_PIX);
  localparam logic [LW-1:0]  L_FRAME = LW'(FRAME_LINES);
  localparam logic [LW-1:0]  L_SAT   = LW'(FRAME_LINES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  rd_state_e      state_q, state_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic           wbank_q, wbank_d;
  logic [KW-1:0]  k_q, k_d;
  logic           pv_q;
  logic [LW-1:0]  line_cnt_q, line_cnt_d;
  logic           rd_vs_q, rd_vs_d;
  logic           rd_final_q, rd_final_d;
  logic           vs_drop1_q, vs_drop1_d;
  logic           vs_drop2_q;
  logic [13:0]    vd_q, vd_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           ovr_q, ovr_d;

  // Left half holds columns 0..LINE_PIX-1; right half holds columns
  // LINE_PIX..2*LINE_PIX-1 at offset (column - LINE_PIX). Splitting the halves
  // gives each channel its own write port.
  logic [13:0] mem_l [2][LINE_PIX];
  logic [13:0] mem_r [2][LINE_PIX];

  logic           cap_we;
  logic           line_end;
  logic           complete;
  logic           start_rd;
  logic [KIW-1:0] k_idx;
  logic [KIW-1:0] r_idx;
  logic [13:0]    wl, wr;
  logic [13:0]    rd_word;
  logic [LW-1:0]  line_inc;
  logic [LW-1:0]  line_new;

  assign cap_we   = pix_valid && (k_q < K_FULL);
  assign line_end = pv_q && !pix_valid;
  assign complete = line_end && (k_q == K_FULL);
  assign start_rd = complete && (state_q == IDLE);
  assign k_idx    = k_q[KIW-1:0];
  assign r_idx    = I_LAST - k_idx;
  assign line_inc = (line_cnt_q == L_SAT) ? line_cnt_q : line_cnt_q + LW'(1);
  // A line that ends together with frame_start becomes line 1 of the new frame.
  assign line_new = frame_start ? LW'(1) : line_inc;

`ifdef USHI_TEST_PATTERN_EN
  assign wl = 14'(k_q);
  assign wr = 14'(A_LAST - AW'(k_q));
`else
  assign wl = AFE_DL;
  assign wr = AFE_DR;
`endif

  // Capture both channels into the write bank; DR lands mirrored.
  always_ff @(posedge CLK_60M) begin
    if (cap_we) begin
      mem_l[wbank_q][k_idx] <= wl;
      mem_r[wbank_q][r_idx] <= wr;
    end
  end

  // Read port on the bank not being captured.
  always_comb begin
    rd_word = '0;
    if (rd_addr_q < A_HALF) rd_word = mem_l[!wbank_q][KIW'(rd_addr_q)];
    else                    rd_word = mem_r[!wbank_q][KIW'(rd_addr_q - A_HALF)];
  end

  // Next-state for readout FSM, capture counter, line counter and outputs.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    wbank_d    = wbank_q;
    k_d        = k_q;
    line_cnt_d = line_cnt_q;
    rd_vs_d    = rd_vs_q;
    rd_final_d = rd_final_q;
    vs_drop1_d = 1'b0;
    vs_d       = vs_q;
    ovr_d      = complete && (state_q == READ);
    hs_d       = (state_q == READ);
    vd_d       = (state_q == READ) ? rd_word : 14'd0;

    case (state_q)
      IDLE: begin
        if (start_rd) begin
          state_d   = READ;
          rd_addr_d = '0;
          wbank_d   = !wbank_q;
        end
      end
      READ: begin
        if (rd_addr_q == A_LAST) begin
          state_d    = IDLE;
          rd_addr_d  = '0;
          vs_drop1_d = rd_final_q;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap_we) k_d = k_q + KW'(1);
    if (line_end || frame_start) k_d = '0;

    if (frame_start) line_cnt_d = start_rd ? LW'(1) : '0;
    else if (start_rd) line_cnt_d = line_inc;

    // Per-readout frame membership; a readout already running when
    // frame_start arrives no longer belongs to any frame.
    if (start_rd) begin
      rd_vs_d    = (line_new <= L_FRAME);
      rd_final_d = (line_new == L_FRAME);
    end else if (frame_start) begin
      rd_vs_d    = 1'b0;
      rd_final_d = 1'b0;
    end

    // Drop is timed to land one cycle after HSYNC falls on the last frame line.
    if (vs_drop2_q) vs_d = 1'b0;
    if ((state_q == READ) && rd_vs_q) vs_d = 1'b1;
    if (frame_start) vs_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge CLK_60M or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      wbank_q    <= 1'b0;
      k_q        <= '0;
      pv_q       <= 1'b0;
      line_cnt_q <= '0;
      rd_vs_q    <= 1'b0;
      rd_final_q <= 1'b0;
      vs_drop1_q <= 1'b0;
      vs_drop2_q <= 1'b0;
      vd_q       <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      wbank_q    <= wbank_d;
      k_q        <= k_d;
      pv_q       <= pix_valid;
      line_cnt_q <= line_cnt_d;
      rd_vs_q    <= rd_vs_d;
      rd_final_q <= rd_final_d;
      vs_drop1_q <= vs_drop1_d;
      vs_drop2_q <= vs_drop1_q;
      vd_q       <= vd_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      ovr_q      <= ovr_d;
    end
  end

  assign CPU_VD    = vd_q;
  assign CPU_HSYNC = hs_q;
  assign CPU_VSYNC = vs_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_ccd_line_merge.sv
// Testbench for ccd_line_merge with LINE_PIX=4, FRAME_LINES=2.
module tb_ccd_line_merge;

  localparam int LP   = 4;
  localparam int FL   = 2;
  localparam int NPIX = 2 * LP;

  typedef logic [13:0] half_t [LP];

  typedef struct packed {
    logic [NPIX-1:0][13:0] px;
    logic [31:0]           len;
    logic [31:0]           rise;
    logic                  vs_first;
    logic [31:0]           vs_hi;
    logic                  vs_fall;
    logic                  vs_post;
  } line_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pix_valid;
  logic [13:0] dl_in, dr_in;
  logic [13:0] vd;
  logic        hsync, vsync, ovr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  line_t cur;
  line_t lines[$];
  bit    in_line = 0;
  bit    post_pending = 0;
  int    ovr_cnt = 0;
  int    ovr_cyc = -1;
  int    vd_leak = 0;

  ccd_line_merge #(.LINE_PIX(LP), .FRAME_LINES(FL)) dut (
    .CLK_60M    (clk),
    .CPU_RST    (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .AFE_DL     (dl_in),
    .AFE_DR     (dr_in),
    .CPU_VD     (vd),
    .CPU_HSYNC  (hsync),
    .CPU_VSYNC  (vsync),
    .overrun    (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects each HSYNC run as one line record.
  always @(negedge clk) begin
    if (post_pending) begin
      cur.vs_post = vsync;
      lines.push_back(cur);
      post_pending = 0;
    end
    if (hsync) begin
      if (!in_line) begin
        cur = '0;
        cur.rise = 32'(cyc);
        cur.vs_first = vsync;
        in_line = 1;
      end
      if (cur.len < NPIX) cur.px[cur.len[2:0]] = vd;
      cur.len = cur.len + 1;
      cur.vs_hi = cur.vs_hi + 32'(vsync);
    end else begin
      if (in_line) begin
        in_line = 0;
        cur.vs_fall = vsync;
        post_pending = 1;
      end
      if (vd !== 14'd0) vd_leak++;
    end
    if (ovr) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Expected pixel at output column c: left channel in order, then the right
  // channel whose samples arrived from the last column backwards.
  function automatic logic [13:0] exp_pix(input half_t dl, input half_t dr, input int c);
`ifdef USHI_TEST_PATTERN_EN
    return 14'(c);
`else
    if (c < LP) return dl[c];
    return dr[2 * LP - 1 - c];
`endif
  endfunction

  task automatic rand_half(output half_t h);
    for (int i = 0; i < LP; i++) h[i] = 14'($urandom);
  endtask

  task automatic send_line(input half_t dl, input half_t dr, input int n, output int fall);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      dl_in = dl[i];
      dr_in = dr[i];
      step();
    end
    pix_valid = 1'b0;
    dl_in = 14'($urandom);
    dr_in = 14'($urandom);
    fall = cyc;
  endtask

  task automatic wait_lines(input int n, input int budget, input string tag);
    int i = 0;
    while (lines.size() < n && i < budget) begin
      step();
      i++;
    end
    chk(tag, 32'(lines.size()), 32'(n));
  endtask

  task automatic check_line(input string tag, input line_t l, input half_t dl, input half_t dr);
    chk({tag, "_len"}, l.len, 32'(NPIX));
    for (int c = 0; c < NPIX; c++)
      chk($sformatf("%s_px%0d", tag, c), 32'(l.px[c]), 32'(exp_pix(dl, dr, c)));
  endtask

  half_t a, b, c, d, e, f;
  half_t rdl[6];
  half_t rdr[6];
  int    fa, fb, fc, o0;

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    dl_in = '0;
    dr_in = '0;
    idle(3);
    chk("rst_vd", 32'(vd), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_vsync", 32'(vsync), 32'd0);
    chk("rst_overrun", 32'(ovr), 32'd0);
    rst = 1'b0;
    idle(2);

    // Channel reversal with fixed data; first line after reset is frame line 1.
    a = '{14'd10, 14'd11, 14'd12, 14'd13};
    b = '{14'd27, 14'd26, 14'd25, 14'd24};
    send_line(a, b, LP, fa);
    wait_lines(1, 30, "rev_count");
    check_line("rev", lines[0], a, b);
    chk("rev_latency", lines[0].rise, 32'(fa + 2));
    chk("rev_vs_first", 32'(lines[0].vs_first), 32'd1);
    chk("rev_vs_hi", lines[0].vs_hi, 32'(NPIX));
    idle(4);

    // Short line is silently dropped; the following full line is intact.
    lines.delete();
    o0 = ovr_cnt;
    rand_half(a);
    rand_half(b);
    send_line(a, b, LP - 1, fa);
    idle(20);
    chk("short_none", 32'(lines.size()), 32'd0);
    chk("short_ovr", 32'(ovr_cnt), 32'(o0));
    rand_half(a);
    rand_half(b);
    send_line(a, b, LP, fa);
    wait_lines(1, 30, "short_next_count");
    check_line("short_next", lines[0], a, b);
    idle(6);

    // Second line completes while the first is still being read out.
    lines.delete();
    o0 = ovr_cnt;
    rand_half(a);
    rand_half(b);
    rand_half(c);
    rand_half(d);
    send_line(a, b, LP, fa);
    step();
    send_line(c, d, LP, fb);
    wait_lines(1, 30, "ovr_first_count");
    idle(15);
    chk("ovr_only_one", 32'(lines.size()), 32'd1);
    check_line("ovr_first", lines[0], a, b);
    chk("ovr_pulses", 32'(ovr_cnt), 32'(o0 + 1));
    chk("ovr_time", 32'(ovr_cyc), 32'(fb + 1));
    lines.delete();
    rand_half(a);
    rand_half(b);
    send_line(a, b, LP, fa);
    wait_lines(1, 30, "ovr_after_count");
    check_line("ovr_after", lines[0], a, b);
    idle(6);

    // Frame: lines 1-2 under VSYNC, line 3 emitted with VSYNC low,
    // frame_start during line 3 leaves it running.
    lines.delete();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    idle(3);
    rand_half(a);
    rand_half(b);
    rand_half(c);
    rand_half(d);
    rand_half(e);
    rand_half(f);
    send_line(a, b, LP, fa);
    idle(12);
    send_line(c, d, LP, fb);
    idle(12);
    send_line(e, f, LP, fc);
    idle(4);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_lines(3, 30, "frm_count");
    idle(4);
    chk("frm_l1_vs_first", 32'(lines[0].vs_first), 32'd1);
    chk("frm_l1_vs_hi", lines[0].vs_hi, 32'(NPIX));
    chk("frm_l1_vs_post", 32'(lines[0].vs_post), 32'd1);
    chk("frm_l2_vs_hi", lines[1].vs_hi, 32'(NPIX));
    chk("frm_l2_vs_fall", 32'(lines[1].vs_fall), 32'd1);
    chk("frm_l2_vs_post", 32'(lines[1].vs_post), 32'd0);
    chk("frm_l3_vs_hi", lines[2].vs_hi, 32'd0);
    check_line("frm_l3", lines[2], e, f);
    chk("frm_vs_low", 32'(vsync), 32'd0);

    // After frame_start the next line opens a new frame.
    lines.delete();
    rand_half(a);
    rand_half(b);
    send_line(a, b, LP, fa);
    wait_lines(1, 30, "frm_new_count");
    chk("frm_new_vs_first", 32'(lines[0].vs_first), 32'd1);
    check_line("frm_new", lines[0], a, b);
    idle(4);

    // frame_start together with a line end: that line is line 1.
    lines.delete();
    rand_half(a);
    rand_half(b);
    rand_half(c);
    rand_half(d);
    send_line(a, b, LP, fa);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    idle(12);
    send_line(c, d, LP, fb);
    wait_lines(2, 30, "sim_count");
    idle(3);
    chk("sim_l1_vs_first", 32'(lines[0].vs_first), 32'd1);
    chk("sim_l2_vs_hi", lines[1].vs_hi, 32'(NPIX));
    chk("sim_l2_vs_post", 32'(lines[1].vs_post), 32'd0);
    check_line("sim_l2", lines[1], c, d);
    idle(4);

    // Reset mid-readout clears outputs immediately.
    lines.delete();
    rand_half(a);
    rand_half(b);
    send_line(a, b, LP, fa);
    idle(4);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_vd", 32'(vd), 32'd0);
    chk("mid_rst_hsync", 32'(hsync), 32'd0);
    chk("mid_rst_vsync", 32'(vsync), 32'd0);
    chk("mid_rst_overrun", 32'(ovr), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("mid_rst_truncated", 32'(lines.size() == 1 && lines[0].len < NPIX), 32'd1);
    lines.delete();
    rand_half(a);
    rand_half(b);
    send_line(a, b, LP, fa);
    wait_lines(1, 30, "post_rst_count");
    check_line("post_rst", lines[0], a, b);
    idle(4);

    // Random data with random spacing that always leaves room for readout.
    lines.delete();
    o0 = ovr_cnt;
    for (int j = 0; j < 6; j++) begin
      rand_half(rdl[j]);
      rand_half(rdr[j]);
      send_line(rdl[j], rdr[j], LP, fa);
      idle(6 + $urandom_range(0, 4));
    end
    wait_lines(6, 40, "rnd_count");
    for (int j = 0; j < 6; j++) check_line($sformatf("rnd%0d", j), lines[j], rdl[j], rdr[j]);
    chk("rnd_no_ovr", 32'(ovr_cnt), 32'(o0));

    chk("vd_zero_outside_hsync", 32'(vd_leak), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
